// File: rtl/mem_ctrl.sv
// Shares one byte-wide RAM port between instruction fetch and the MEM stage.
// Each 8/16/32-bit access is sequenced as byte transactions; reads are assembled little-endian.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  input  logic              flush,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_q, state_d;
  logic [31:0]       base_q, base_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              owner_q, owner_d;  // 1 = MEM stage, 0 = fetch
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       buf_q, buf_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic              if_done_q, if_done_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              mem_done_q, mem_done_d;

  logic [31:0]       byte_addr;
  logic [1:0]        rd_idx;

  assign byte_addr = base_q + {29'd0, cnt_q};
  // cnt_q runs 1..N; the byte arriving now belongs to the previous address
  assign rd_idx    = cnt_q[1:0] - 2'd1;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    n_d         = n_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    ram_addr_d  = ram_addr_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    if_done_d   = 1'b0;
    mem_rdata_d = mem_rdata_q;
    mem_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_req) begin
          base_d     = mem_addr;
          owner_d    = 1'b1;
          wdata_d    = mem_wdata;
          buf_d      = 32'd0;
          cnt_d      = 3'd1;
          ram_addr_d = mem_addr[ADDR_W-1:0];
          case (mem_len)
            2'b00:   n_d = 3'd1;
            2'b01:   n_d = 3'd2;
            default: n_d = 3'd4;
          endcase
          if (mem_we) begin
            state_d    = WRITE;
            ram_dout_d = mem_wdata[7:0];
            ram_wr_d   = 1'b1;
          end else begin
            state_d = READ;
          end
        end else if (if_req) begin
          base_d     = if_addr;
          owner_d    = 1'b0;
          n_d        = 3'd4;
          buf_d      = 32'd0;
          cnt_d      = 3'd1;
          ram_addr_d = if_addr[ADDR_W-1:0];
          state_d    = READ;
        end
      end

      READ: begin
        if (flush && !owner_q) begin
          state_d = IDLE;
        end else begin
          buf_d[{rd_idx, 3'b000} +: 8] = ram_din;
          if (cnt_q == n_q) begin
            state_d = DONE;
            if (owner_q) begin
              mem_rdata_d = buf_d;
              mem_done_d  = 1'b1;
            end else begin
              if_rdata_d = buf_d;
              if_done_d  = 1'b1;
            end
          end else begin
            ram_addr_d = byte_addr[ADDR_W-1:0];
            cnt_d      = cnt_q + 3'd1;
          end
        end
      end

      WRITE: begin
        if (cnt_q == n_q) begin
          state_d    = DONE;
          mem_done_d = 1'b1;
        end else begin
          ram_addr_d = byte_addr[ADDR_W-1:0];
          ram_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          ram_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= 32'd0;
      n_q         <= 3'd0;
      cnt_q       <= 3'd0;
      owner_q     <= 1'b0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      ram_addr_q  <= '0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
      if_rdata_q  <= 32'd0;
      if_done_q   <= 1'b0;
      mem_rdata_q <= 32'd0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      n_q         <= n_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      ram_addr_q  <= ram_addr_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_rdata_q  <= if_rdata_d;
      if_done_q   <= if_done_d;
      mem_rdata_q <= mem_rdata_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;
  assign if_rdata  = if_rdata_q;
  assign if_done   = if_done_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: table of accesses plus hand-written corner sequences.
// The RAM model returns the byte at the currently presented address.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        flush;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .flush(flush),
    .if_rdata(if_rdata), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_wr(ram_wr), .ram_din(ram_din)
  );

  // 64 KiB RAM model aliased on the low address bits; bench preload via its own port
  logic [7:0]  ram_mem [0:65535];
  logic        tb_we = 1'b0;
  logic [15:0] tb_a = 16'd0;
  logic [7:0]  tb_d = 8'd0;

  always @(posedge clk) begin
    if (ram_wr)     ram_mem[ram_addr[15:0]] <= ram_dout;
    else if (tb_we) ram_mem[tb_a] <= tb_d;
  end
  assign ram_din = ram_mem[ram_addr[15:0]];

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_if_last  = 32'd0;
  logic [31:0] exp_mem_last = 32'd0;

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    int          n;
    logic        fl;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    tb_a = a; tb_d = d; tb_we = 1'b1;
    @(posedge clk); #1;
    tb_we = 1'b0;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 32'd0; flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'b00;
    mem_addr = 32'd0; mem_wdata = 32'd0;
  endtask

  // Issue one access, trace the RAM port each cycle and check the done pulse.
  task automatic run(input vec_t v, input int idx);
    int          e;
    int          wr_cnt;
    logic        got;
    logic        own_done;
    logic        oth_done;
    logic [31:0] sh;
    if (v.is_mem) begin
      mem_req = 1'b1; mem_we = v.we; mem_len = v.len;
      mem_addr = v.addr; mem_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    flush = v.fl;
    @(posedge clk); #1;
    // scramble request fields after acceptance; the block must use its latched copy
    mem_addr = 32'hBAD0_0000; mem_wdata = 32'h5A5A_5A5A; mem_len = ~v.len;
    if_addr = 32'hBAD0_1000;
    wr_cnt = 0;
    got = 1'b0;
    for (e = 0; e <= 20 && !got; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      if (ram_wr) wr_cnt++;
      own_done = v.is_mem ? mem_done : if_done;
      oth_done = v.is_mem ? if_done : mem_done;
      chk("other_done", {31'd0, oth_done}, 32'd0);
      if (e < v.n) begin
        chk("ram_addr", ram_addr, v.addr + 32'(e));
        if (v.we) begin
          sh = v.wdata >> (8 * e);
          chk("ram_dout", {24'd0, ram_dout}, {24'd0, sh[7:0]});
        end
      end
      if (own_done) begin
        got = 1'b1;
        chk("latency", 32'(e), 32'(v.n));
        if (!v.is_mem) begin
          chk("if_rdata", if_rdata, v.exp);
          exp_if_last = v.exp;
          chk("mem_rdata_hold", mem_rdata, exp_mem_last);
        end else begin
          if (!v.we) exp_mem_last = v.exp;
          chk("mem_rdata", mem_rdata, exp_mem_last);
          chk("if_rdata_hold", if_rdata, exp_if_last);
        end
      end
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    idle_inputs();
    @(posedge clk); #1;
    chk("done_pulse", {30'd0, if_done, mem_done}, 32'd0);
    chk("wr_count", 32'(wr_cnt), v.we ? 32'(v.n) : 32'd0);
    $display("txn %0d: %s we=%0d addr=%h n=%0d if_rdata=%h mem_rdata=%h",
             idx, v.is_mem ? "MEM" : "IF ", v.we, v.addr, v.n, if_rdata, mem_rdata);
  endtask

  initial begin
    int mem_e;
    int if_e;
    vec_t v;

    //            is_mem we   len    addr          wdata         exp           n  fl
    vecs[0]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,        32'h0000_0513, 4, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0200, 32'h0,        32'hDEAD_BEEF, 4, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 2'b01, 32'h0000_0202, 32'h0,        32'h0000_DEAD, 2, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0201, 32'h0,        32'h0000_00BE, 1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 2'b01, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        2, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 2'b00, 32'h0000_2003, 32'h0,        32'h0000_00AB, 1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 2'b00, 32'h0000_2002, 32'h0,        32'h0000_00CD, 1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 2'b11, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,        4, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0400, 32'h0,        32'hCAFE_F00D, 4, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0,        32'h4433_2211, 4, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 2'b11, 32'h0000_0400, 32'h0,        32'hCAFE_F00D, 4, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 2'b01, 32'h0000_0101, 32'h0,        32'h0000_0005, 2, 1'b1};

    idle_inputs();
    rst = 1'b1;
    poke(16'h0100, 8'h13); poke(16'h0101, 8'h05); poke(16'h0102, 8'h00); poke(16'h0103, 8'h00);
    poke(16'h0200, 8'hEF); poke(16'h0201, 8'hBE); poke(16'h0202, 8'hAD); poke(16'h0203, 8'hDE);
    poke(16'h0300, 8'h93); poke(16'h0301, 8'h00); poke(16'h0302, 8'h10); poke(16'h0303, 8'h00);
    poke(16'hFFFE, 8'h11); poke(16'hFFFF, 8'h22); poke(16'h0000, 8'h33); poke(16'h0001, 8'h44);

    chk("rst_ram_addr", ram_addr, 32'd0);
    chk("rst_ram_wr_dout", {23'd0, ram_wr, ram_dout}, 32'd0);
    chk("rst_dones", {30'd0, if_done, mem_done}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) run(vecs[i], i);

    // Simultaneous requests: MEM first (done after E4), IF accepted at E6, done after E10
    if_req = 1'b1; if_addr = 32'h0000_0100;
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b10; mem_addr = 32'h0000_0200;
    @(posedge clk); #1;
    mem_e = 0; if_e = 0;
    for (int e = 1; e <= 20 && if_e == 0; e++) begin
      @(posedge clk); #1;
      if (e == 6) chk("simul_if_accept_addr", ram_addr, 32'h0000_0100);
      if (mem_done) begin
        mem_e = e;
        chk("simul_mem_rdata", mem_rdata, 32'hDEAD_BEEF);
        mem_req = 1'b0;
      end
      if (if_done) begin
        if_e = e;
        chk("simul_if_rdata", if_rdata, 32'h0000_0513);
        if_req = 1'b0;
      end
    end
    chk("simul_mem_edge", 32'(mem_e), 32'd4);
    chk("simul_if_edge", 32'(if_e), 32'd10);
    exp_mem_last = 32'hDEAD_BEEF;
    exp_if_last = 32'h0000_0513;
    idle_inputs();
    @(posedge clk); #1;
    $display("txn simul: mem_done edge %0d, if_done edge %0d", mem_e, if_e);

    // Flush after E2 of a fetch: no done, no further addresses
    if_req = 1'b1; if_addr = 32'h0000_0300;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("flush_addr_e2", ram_addr, 32'h0000_0302);
    flush = 1'b1; if_req = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("flush_no_done", {31'd0, if_done}, 32'd0);
      chk("flush_addr_hold", ram_addr, 32'h0000_0302);
      @(posedge clk); #1;
    end
    chk("flush_if_rdata_hold", if_rdata, exp_if_last);
    $display("txn flush: fetch at 0x300 aborted");
    v = '{1'b0, 1'b0, 2'b10, 32'h0000_0300, 32'h0, 32'h0010_0093, 4, 1'b0};
    run(v, 100);

    // Reset after E1 of a word store: everything cleared, no done
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10;
    mem_addr = 32'h0000_0500; mem_wdata = 32'h5566_7788;
    @(posedge clk); #1;
    chk("rst_mid_wr_e0", {31'd0, ram_wr}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; mem_req = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("rst_mid_ram_addr", ram_addr, 32'd0);
    chk("rst_mid_ram_dout", {24'd0, ram_dout}, 32'd0);
    chk("rst_mid_mem_rdata", mem_rdata, 32'd0);
    chk("rst_mid_if_rdata", if_rdata, 32'd0);
    rst = 1'b0;
    exp_if_last = 32'd0;
    exp_mem_last = 32'd0;
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      chk("rst_mid_quiet", {30'd0, mem_done, ram_wr}, 32'd0);
      @(posedge clk); #1;
    end
    $display("txn reset: store at 0x500 abandoned");
    v = '{1'b1, 1'b1, 2'b10, 32'h0000_0500, 32'h5566_7788, 32'h0, 4, 1'b0};
    run(v, 101);
    v = '{1'b1, 1'b0, 2'b10, 32'h0000_0500, 32'h0, 32'h5566_7788, 4, 1'b0};
    run(v, 102);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
